// File: rtl/wb_pkg.sv
// Shared writeback definitions: register-file geometry, queued-entry layout and select codes.
// Decode also imports this package to size its view of pend_mask.
package wb_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned WB_WORD_SIZE = 16;

    typedef struct packed {
        logic                    live;
        logic [REG_ADDR_W-1:0]   rd;
        logic [WB_WORD_SIZE-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_ALU,
        SEL_FIFO
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular load-result buffer with per-entry kill-by-rd and a live/rd view of every slot.
// An entry's live bit is cleared when it pops, so the live view covers occupied slots only.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W    = PTR_W + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  logic                                  push_live,
    input  logic [REG_ADDR_W-1:0]                 push_rd,
    input  logic [WORD_SIZE-1:0]                  push_data,
    input  logic                                  pop,
    input  logic                                  kill_en,
    input  logic [REG_ADDR_W-1:0]                 kill_rd,
    output logic [CNT_W-1:0]                      count,
    output logic                                  head_live,
    output logic [REG_ADDR_W-1:0]                 head_rd,
    output logic [WORD_SIZE-1:0]                  head_data,
    output logic [DEPTH-1:0]                      live_view,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      rd_view
);

    logic [PTR_W-1:0]                  rptr;
    logic [PTR_W-1:0]                  wptr;
    logic [DEPTH-1:0]                  live_q;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  rd_q;
    logic [DEPTH-1:0][WORD_SIZE-1:0]   data_q;

    // Kill is applied before the push so a same-cycle push keeps the live value it was given.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
            live_q <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            if (kill_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == kill_rd) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                live_q[rptr] <= 1'b0;
                rptr         <= rptr + PTR_W'(1);
            end
            if (push) begin
                live_q[wptr] <= push_live;
                rd_q[wptr]   <= push_rd;
                data_q[wptr] <= push_data;
                wptr         <= wptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_live = live_q[rptr];
    assign head_rd   = rd_q[rptr];
    assign head_data = data_q[rptr];
    assign live_view = live_q;
    assign rd_view   = rd_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto one registered register-file write port, ALU first,
// and publishes the mask of registers whose writes are still in flight.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [WORD_SIZE-1:0]  alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [WORD_SIZE-1:0]  ld_data,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [WORD_SIZE-1:0]  wb_data,
    output logic [NUM_REGS-1:0]   pend_mask
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic                             alu_write;
    logic                             push;
    logic                             push_live;
    logic                             pop;
    logic [CNT_W-1:0]                 fifo_count;
    logic                             head_live;
    logic [REG_ADDR_W-1:0]            head_rd;
    logic [WORD_SIZE-1:0]             head_data;
    logic [DEPTH-1:0]                 live_view;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_view;
    wb_sel_e                          sel;

    assign alu_write = alu_valid && (alu_rd != '0);
    assign ld_ready  = rst && (fifo_count < FULL_COUNT);
    assign push      = ld_valid && ld_ready && (ld_rd != '0);
    // A load arriving alongside an ALU write to the same rd is the older value: queue it dead.
    assign push_live = !(alu_write && (alu_rd == ld_rd));
    assign pop       = (sel == SEL_FIFO);

    always_comb begin
        sel = SEL_IDLE;
        if (alu_write) begin
            sel = SEL_ALU;
        end else if (fifo_count != '0) begin
            sel = SEL_FIFO;
        end
    end

    wb_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_live (push_live),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (pop),
        .kill_en   (alu_write),
        .kill_rd   (alu_rd),
        .count     (fifo_count),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_data (head_data),
        .live_view (live_view),
        .rd_view   (rd_view)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            case (sel)
                SEL_ALU: begin
                    wb_en   <= 1'b1;
                    wb_rd   <= alu_rd;
                    wb_data <= alu_data;
                end
                SEL_FIFO: begin
                    wb_en <= head_live;
                    if (head_live) begin
                        wb_rd   <= head_rd;
                        wb_data <= head_data;
                    end
                end
                default: wb_en <= 1'b0;
            endcase
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_view[i]) begin
                pend_mask[rd_view[i]] = 1'b1;
            end
        end
        if (wb_en) begin
            pend_mask[wb_rd] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a queue-based model of the port.
module tb_writeback_arbiter;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [15:0] ld_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [15:0] wb_data;
    logic [31:0] pend_mask;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arbiter #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued loads in acceptance order plus the last written port values.
    typedef struct {
        bit live;
        int rd;
        int data;
    } ent_t;

    ent_t q[$];
    bit   m_en;
    int   m_rd;
    int   m_data;
    bit   m_alu_w;
    bit   m_acc;
    ent_t m_head;
    ent_t m_new;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_en   = 1'b0;
            m_rd   = 0;
            m_data = 0;
        end else begin
            m_alu_w = alu_valid && (alu_rd != 0);
            m_acc   = ld_valid && (q.size() < DEPTH);
            if (m_alu_w) begin
                foreach (q[i]) if (q[i].rd == int'(alu_rd)) q[i].live = 1'b0;
                m_en   = 1'b1;
                m_rd   = int'(alu_rd);
                m_data = int'(alu_data);
            end else if (q.size() > 0) begin
                m_head = q.pop_front();
                m_en   = m_head.live;
                if (m_head.live) begin
                    m_rd   = m_head.rd;
                    m_data = m_head.data;
                end
            end else begin
                m_en = 1'b0;
            end
            if (m_acc && ld_rd != 0) begin
                m_new.live = !(m_alu_w && alu_rd == ld_rd);
                m_new.rd   = int'(ld_rd);
                m_new.data = int'(ld_data);
                q.push_back(m_new);
            end
        end
    end

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
        if (m_en) m[m_rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("model wb_en", 32'(wb_en), 32'(m_en));
            chk("model wb_rd", 32'(wb_rd), m_rd);
            chk("model wb_data", 32'(wb_data), m_data);
            chk("model ld_ready", 32'(ld_ready), 32'(q.size() < DEPTH));
            chk("model pend_mask", pend_mask, model_mask());
        end
    end

    task automatic cyc(input logic av, input logic [4:0] ar, input logic [15:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [15:0] ld);
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lr;
        ld_data   = ld;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b0;
        #1;
        chk("rst wb_en", 32'(wb_en), 0);
        chk("rst wb_rd", 32'(wb_rd), 0);
        chk("rst wb_data", 32'(wb_data), 0);
        chk("rst ld_ready", 32'(ld_ready), 0);
        chk("rst pend_mask", pend_mask, 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        // Reset held with traffic present
        cyc(1'b1, 5'd3, 16'h1111, 1'b1, 5'd4, 16'h2222);
        chk("t1 wb_en", 32'(wb_en), 0);
        chk("t1 ld_ready", 32'(ld_ready), 0);
        cyc(1'b1, 5'd6, 16'h3333, 1'b1, 5'd7, 16'h4444);
        chk("t1 wb_rd", 32'(wb_rd), 0);
        chk("t1 wb_data", 32'(wb_data), 0);
        chk("t1 pend_mask", pend_mask, 0);
        #2 rst = 1'b1;
        #1 chk("t1 ld_ready after release", 32'(ld_ready), 1);

        // ALU only
        cyc(1'b1, 5'd3, 16'h1234, 1'b0, 5'd0, 16'h0);
        chk("t2 wb_en", 32'(wb_en), 1);
        chk("t2 wb_rd", 32'(wb_rd), 3);
        chk("t2 wb_data", 32'(wb_data), 32'h1234);
        chk("t2 pend r3", 32'(pend_mask), 32'h8);
        cyc(1'b1, 5'd0, 16'h5555, 1'b0, 5'd0, 16'h0);
        chk("t2 rd0 wb_en", 32'(wb_en), 0);
        chk("t2 rd0 hold rd", 32'(wb_rd), 3);

        // Load buffered behind three ALU writes
        cyc(1'b1, 5'd9, 16'h0909, 1'b1, 5'd5, 16'hAAAA);
        chk("t3 pend5 a", 32'(pend_mask[5]), 1);
        chk("t3 alu first", 32'(wb_rd), 9);
        cyc(1'b1, 5'd10, 16'h0A0A, 1'b0, 5'd0, 16'h0);
        chk("t3 pend5 b", 32'(pend_mask[5]), 1);
        cyc(1'b1, 5'd11, 16'h0B0B, 1'b0, 5'd0, 16'h0);
        chk("t3 pend5 c", 32'(pend_mask[5]), 1);
        idle();
        chk("t3 ld wb_en", 32'(wb_en), 1);
        chk("t3 ld wb_rd", 32'(wb_rd), 5);
        chk("t3 ld wb_data", 32'(wb_data), 32'hAAAA);
        chk("t3 pend5 d", 32'(pend_mask[5]), 1);
        idle();
        chk("t3 pend clear", pend_mask, 0);

        // Fill the FIFO under continuous ALU writes
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 5'(20 + i), 16'(16'h2000 + i), 1'b1, 5'(i), 16'(16'h0100 + i));
        end
        chk("t4 full ld_ready", 32'(ld_ready), 0);
        chk("t4 full pend", pend_mask, 32'h0100_001E);
        cyc(1'b1, 5'd25, 16'h2025, 1'b1, 5'd5, 16'h0105);
        chk("t4 still full", 32'(ld_ready), 0);
        cyc(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 16'h0105);
        chk("t4 pop1 rd", 32'(wb_rd), 1);
        chk("t4 pop1 data", 32'(wb_data), 32'h0101);
        chk("t4 ready after pop", 32'(ld_ready), 1);
        cyc(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 16'h0105);
        chk("t4 pop2 rd", 32'(wb_rd), 2);
        for (int i = 3; i <= 5; i++) begin
            idle();
            chk("t4 order wb_en", 32'(wb_en), 1);
            chk("t4 order rd", 32'(wb_rd), i);
            chk("t4 order data", 32'(wb_data), 32'h0100 + i);
        end
        idle();
        chk("t4 drained", 32'(wb_en), 0);

        // WAW kill of a queued load, then a same-cycle kill
        cyc(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 16'h0001);
        chk("t5 queued pend7", pend_mask, 32'h80);
        cyc(1'b1, 5'd7, 16'h0002, 1'b0, 5'd0, 16'h0);
        chk("t5 alu rd7", 32'(wb_rd), 7);
        chk("t5 alu data", 32'(wb_data), 32'h0002);
        idle();
        chk("t5 dead pop wb_en", 32'(wb_en), 0);
        chk("t5 data kept", 32'(wb_data), 32'h0002);
        chk("t5 pend7 clear", pend_mask, 0);
        cyc(1'b1, 5'd8, 16'h0BBB, 1'b1, 5'd8, 16'h0CCC);
        chk("t5 same-cycle pend", pend_mask, 32'h100);
        idle();
        chk("t5 same-cycle dead", 32'(wb_en), 0);
        chk("t5 same-cycle data", 32'(wb_data), 32'h0BBB);

        // Mid-operation reset with three queued loads
        cyc(1'b1, 5'd12, 16'h0C0C, 1'b1, 5'd1, 16'hD001);
        cyc(1'b1, 5'd13, 16'h0D0D, 1'b1, 5'd2, 16'hD002);
        cyc(1'b1, 5'd14, 16'h0E0E, 1'b1, 5'd3, 16'hD003);
        chk("t6 queued pend", pend_mask, 32'h0000_400E);
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t6 no stale write", 32'(wb_en), 0);
            chk("t6 pend empty", pend_mask, 0);
        end

        // Random traffic on a narrow register range to provoke kills and collisions
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) reset_pulse();
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom),
                1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
